te_array: RTL and testbench
===========================

TE_ARRAY -- requirements
Module: te_array

Interface
REQ-001 Parameter BITS, default 4: width of each channel's delay value, so delays range 0..2^BITS-1 clocks.
REQ-002 Parameter CH, default 1: number of independent delay channels.
REQ-003 Parameter DEPTH, default 2: number of pending-edge entries per channel in transport mode (at least 1).
REQ-004 Parameter INERTIAL, default 0: 0 selects transport mode, 1 selects inertial mode (DEPTH ignored, 1 entry).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 tin  input  CH  per-channel transition input, synchronous to clk; no internal synchroniser.
REQ-008 din  input  CH*BITS  per-channel delay; channel i uses bits [i*BITS +: BITS].
REQ-009 clr_ovf  input  1  synchronous clear of all ovf flags.
REQ-010 tout  output  CH  per-channel delayed copy of tin.
REQ-011 busy  output  CH  channel has at least one pending edge.
REQ-012 ovf  output  CH  sticky flag: an edge was stalled because the channel FIFO was full.

Function
REQ-013 A free-running time counter NOW shall have width TW = BITS+clog2(DEPTH)+1, increment every clock and wrap modulo 2^TW.
REQ-014 Each channel shall hold a level register lvl, equal to the last level scheduled.
REQ-015 An edge is detected at clock edge k when tin[i] != lvl[i].
REQ-016 At detection, din[i] shall be sampled, and the entry {level=tin[i], exp=NOW+max(din[i],1)} shall be pushed. lvl[i] then becomes tin[i].
REQ-017 Consequently, tout[i] shall change at clock edge k+max(din[i],1): din=0 gives a 1-cycle delay, and din=d>0 gives a d-cycle delay.
REQ-018 The head entry shall pop when NOW == head.exp. On pop, tout[i] shall take head.level.
REQ-019 Transport ordering: a pushed exp shall be clamped to no earlier than tail.exp+1, so that tout edges keep the same order as tin edges.
REQ-020 Transport full case: if the FIFO is full and no pop happens in the same cycle, the edge is stalled.
 - lvl is not updated and ovf[i] is set.
 - Detection retries every cycle until space frees.
 - A push and a pop in the same cycle on a full FIFO shall be accepted.
REQ-021 Inertial cancel: in inertial mode, an edge detected while an entry is pending shall cancel that entry, set lvl to tin, and push nothing. Pulses shorter than the delay are swallowed.
REQ-022 Inertial collision: if the pending entry expires on the same edge as an opposing tin edge, the expiry shall take effect, and the new edge shall then be scheduled normally per REQ-016.
REQ-023 busy[i] shall be 1 exactly when channel i's FIFO is non-empty.
REQ-024 When clr_ovf and a new overflow occur in the same cycle, set shall take priority over clear.
REQ-025 Channels shall be fully independent and share only NOW and clr_ovf.

Reset
REQ-026 While rst=1, the block shall hold these values:
 - tout=0, lvl=0, busy=0, ovf=0, NOW=0;
 - all FIFOs empty.
REQ-027 An assertion of rst during pending delays shall discard all pending entries with no further tout transitions.
REQ-028 After rst deasserts, any tin=1 shall be detected as an edge on the first clock.

Structure
REQ-029 A package te_pkg shall hold:
 - the clog2 function;
 - the mode constants TE_TRANSPORT=0 and TE_INERTIAL=1;
 - the TW width derivation.
REQ-030 A sub-module te_chan shall implement one channel: lvl, the FIFO/pending entry, the compare logic and tout.
REQ-031 te_array shall instantiate CH copies of te_chan via generate and own NOW.

Verification
REQ-032 Sweep (BITS=4, transport): for each din 0..15, toggle tin once and hold it. tout shall toggle exactly max(din,1) clocks later, and busy shall be high for that span.
REQ-033 Transport pulse (DEPTH=2, din=8): tin pulses high for 3 clocks. tout shall reproduce the 3-clock pulse starting 8 clocks later.
REQ-034 Reorder clamp (din=10 for the rising edge, then din=1 for the falling edge 2 clocks later): the tout rise shall occur at +10 and the fall at +11, never before the rise.
REQ-035 Overflow (DEPTH=2, din=15): issue 3 edges on consecutive clocks.
 - ovf=1 from the third edge.
 - The third edge shall be scheduled once the first pops.
 - clr_ovf shall return ovf to 0.
REQ-036 Inertial (din=6): a 4-clock tin pulse shall leave tout constant and busy=0 afterwards. A 7-clock pulse shall appear on tout delayed by 6.
REQ-037 Reset mid-delay (din=12): assert rst 5 clocks after the edge. tout shall stay 0 and busy 0, with no later transition. With CH=2, channel 1 shall be unaffected by channel 0 activity before reset.

Source files
------------

// File: rtl/te_pkg.sv
// te_pkg: shared constants and width helpers for the transition-delay array
package te_pkg;

    localparam int TE_TRANSPORT = 0;
    localparam int TE_INERTIAL  = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // NOW must span the longest clamped schedule horizon plus one wrap bit
    function automatic int tw(input int bits, input int depth);
        return bits + clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/te_if.sv
// te_if: per-channel transition/delay inputs and delayed outputs
interface te_if #(
    parameter int BITS = 4,
    parameter int CH   = 1
);

    logic [CH-1:0]      tin;
    logic [CH*BITS-1:0] din;
    logic               clr_ovf;
    logic [CH-1:0]      tout;
    logic [CH-1:0]      busy;
    logic [CH-1:0]      ovf;

    modport master (output tin, din, clr_ovf, input tout, busy, ovf);
    modport slave  (input tin, din, clr_ovf, output tout, busy, ovf);

endinterface

// File: rtl/te_chan.sv
// te_chan: one delay channel holding level, pending-edge FIFO and delayed output
module te_chan
    import te_pkg::*;
#(
    parameter int BITS     = 4,
    parameter int DEPTH    = 2,
    parameter int INERTIAL = 0,
    parameter int TW       = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [TW-1:0]   i_now,
    input  logic            i_tin,
    input  logic [BITS-1:0] i_din,
    input  logic            i_clr_ovf,
    output logic            o_tout,
    output logic            o_busy,
    output logic            o_ovf
);

    localparam int D  = (INERTIAL == TE_INERTIAL) ? 1 : DEPTH;
    localparam int PW = (clog2(D) > 0) ? clog2(D) : 1;
    localparam int N  = 2 ** PW;
    localparam int CW = clog2(D + 1);

    logic          r_lvl;
    logic          r_tout;
    logic          r_ovf;
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_cnt;
    logic          r_ql [N];
    logic [TW-1:0] r_qe [N];

    logic          w_pop;
    logic          w_edge;
    logic          w_full;
    logic          w_cancel;
    logic          w_push;
    logic          w_stall;
    logic [PW-1:0] w_tl;
    logic [TW-1:0] w_base;
    logic [TW-1:0] w_gap;
    logic [TW-1:0] w_exp;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop    = (r_cnt != '0) && (i_now == r_qe[r_rd]);
    assign w_edge   = i_tin != r_lvl;
    assign w_full   = r_cnt == CW'(D);
    assign w_cancel = (INERTIAL == TE_INERTIAL) && w_edge && (r_cnt != '0) && !w_pop;
    assign w_push   = w_edge && !w_cancel && (!w_full || w_pop);
    assign w_stall  = w_edge && !w_cancel && !w_push;
    assign w_tl     = (r_wr == '0) ? PW'(D - 1) : r_wr - 1'b1;
    assign w_base   = (i_din == '0) ? TW'(1) : TW'(i_din);
    // distances are taken relative to NOW so the wrap of the time counter is harmless
    assign w_gap    = r_qe[w_tl] - i_now + TW'(1);
    assign w_exp    = i_now + (((r_cnt != '0) && (w_gap > w_base)) ? w_gap : w_base);

    assign o_tout = r_tout;
    assign o_busy = r_cnt != '0;
    assign o_ovf  = r_ovf;

    // FIFO payload storage; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ql[r_wr] <= i_tin;
            r_qe[r_wr] <= w_exp;
        end
    end

    // channel control: pop to tout, push/cancel, level tracking and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lvl  <= 1'b0;
            r_tout <= 1'b0;
            r_ovf  <= 1'b0;
            r_rd   <= '0;
            r_wr   <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_pop) begin
                r_tout <= r_ql[r_rd];
                r_rd   <= inc(r_rd);
            end
            if (w_push) r_wr <= inc(r_wr);
            if (w_edge && !w_stall) r_lvl <= i_tin;
            r_cnt <= w_cancel ? '0 : r_cnt + CW'(w_push) - CW'(w_pop);
            r_ovf <= w_stall | (r_ovf & ~i_clr_ovf);
        end
    end

endmodule

// File: rtl/te_array.sv
// te_array: CH independent transition-delay channels sharing one time counter
module te_array
    import te_pkg::*;
#(
    parameter int BITS     = 4,
    parameter int CH       = 1,
    parameter int DEPTH    = 2,
    parameter int INERTIAL = TE_TRANSPORT
) (
    input logic clk,
    input logic rst,
    te_if.slave bus
);

    localparam int TW = tw(BITS, DEPTH);

    logic [TW-1:0] r_now;

    // free-running time base, wraps modulo 2^TW
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_now <= '0;
        else     r_now <= r_now + 1'b1;
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        te_chan #(
            .BITS     (BITS),
            .DEPTH    (DEPTH),
            .INERTIAL (INERTIAL),
            .TW       (TW)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_now     (r_now),
            .i_tin     (bus.tin[i]),
            .i_din     (bus.din[i*BITS +: BITS]),
            .i_clr_ovf (bus.clr_ovf),
            .o_tout    (bus.tout[i]),
            .o_busy    (bus.busy[i]),
            .o_ovf     (bus.ovf[i])
        );
    end

endmodule

// File: tb/tb_te_array.sv
// tb_te_array: transport and inertial arrays checked against an event-queue model
module tb_te_array;
    import te_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    te_if #(.BITS(4), .CH(2)) bt ();
    te_if #(.BITS(4), .CH(2)) bi ();

    te_array #(.BITS(4), .CH(2), .DEPTH(2), .INERTIAL(TE_TRANSPORT)) u_t (.clk(clk), .rst(rst), .bus(bt));
    te_array #(.BITS(4), .CH(2), .DEPTH(2), .INERTIAL(TE_INERTIAL))  u_i (.clk(clk), .rst(rst), .bus(bi));

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic h_tout [4][8192];
    logic h_busy [4][8192];

    // model: index 0,1 = transport channels, 2,3 = inertial channels
    typedef struct {logic l; int t;} ev_t;
    ev_t  q [4][$];
    logic m_lvl [4];
    logic m_tout [4];
    logic m_ovf [4];
    int   t_now;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic int nxt(input int ch, input int idx);
        for (int j = idx + 1; j <= cyc && j < 8192; j++)
            if (h_tout[ch][j] != h_tout[ch][idx]) return j;
        return -1;
    endfunction

    // reference: every edge becomes a timestamped event; time is an unbounded integer
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_now = 0;
            for (int i = 0; i < 4; i++) begin
                q[i].delete();
                m_lvl[i] = 1'b0;
                m_tout[i] = 1'b0;
                m_ovf[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic ti, clr, set;
                int d, e, ch;
                ch = i % 2;
                ti  = (i < 2) ? bt.tin[ch] : bi.tin[ch];
                d   = (i < 2) ? int'(bt.din[ch*4 +: 4]) : int'(bi.din[ch*4 +: 4]);
                clr = (i < 2) ? bt.clr_ovf : bi.clr_ovf;
                set = 1'b0;
                if (d == 0) d = 1;
                if (q[i].size() != 0 && q[i][0].t == t_now) begin
                    m_tout[i] = q[i][0].l;
                    void'(q[i].pop_front());
                end
                if (ti != m_lvl[i]) begin
                    if (i >= 2) begin
                        if (q[i].size() != 0) q[i].delete();
                        else q[i].push_back('{ti, t_now + d});
                        m_lvl[i] = ti;
                    end else if (q[i].size() < 2) begin
                        e = t_now + d;
                        if (q[i].size() != 0 && q[i][$].t + 1 > e) e = q[i][$].t + 1;
                        q[i].push_back('{ti, e});
                        m_lvl[i] = ti;
                    end else begin
                        m_ovf[i] = 1'b1;
                        set = 1'b1;
                    end
                end
                if (clr && !set) m_ovf[i] = 1'b0;
            end
            t_now++;
        end
    end

    // per-cycle comparison against the model, plus history for directed checks
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 4; i++) begin
            logic a_t, a_b, a_o;
            a_t = (i < 2) ? bt.tout[i%2] : bi.tout[i%2];
            a_b = (i < 2) ? bt.busy[i%2] : bi.busy[i%2];
            a_o = (i < 2) ? bt.ovf[i%2]  : bi.ovf[i%2];
            if (cyc < 8192) begin
                h_tout[i][cyc] = a_t;
                h_busy[i][cyc] = a_b;
            end
            chk($sformatf("model tout[%0d]", i), int'(a_t), int'(m_tout[i]));
            chk($sformatf("model busy[%0d]", i), int'(a_b), int'(q[i].size() != 0));
            chk($sformatf("model ovf[%0d]", i), int'(a_o), int'(m_ovf[i]));
        end
    end

    initial begin
        int st, r, f, nb, e, thr;
        bt.tin = '0; bt.din = '0; bt.clr_ovf = 1'b0;
        bi.tin = '0; bi.din = '0; bi.clr_ovf = 1'b0;
        rst = 1'b1;
        tick(3);
        chk("reset tout", int'(bt.tout), 0);
        chk("reset busy", int'(bt.busy), 0);
        chk("reset ovf", int'(bt.ovf), 0);
        chk("reset inertial tout", int'(bi.tout), 0);
        rst = 1'b0;
        tick(2);

        for (int d = 0; d < 16; d++) begin
            bt.din[3:0] = 4'(d);
            bt.tin[0] = ~bt.tin[0];
            st = cyc;
            tick(20);
            e = (d == 0) ? 1 : d;
            chk($sformatf("sweep delay d=%0d", d), nxt(0, st) - st - 1, e);
            nb = 0;
            for (int j = st + 1; j <= st + 20; j++) nb += int'(h_busy[0][j]);
            chk($sformatf("sweep busy span d=%0d", d), nb, e);
        end

        bt.din[3:0] = 4'd8;
        bt.tin[0] = 1'b1; st = cyc; tick(3);
        bt.tin[0] = 1'b0; tick(15);
        r = nxt(0, st); f = nxt(0, r);
        chk("pulse delay", r - st - 1, 8);
        chk("pulse width", f - r, 3);

        bt.din[3:0] = 4'd10;
        bt.tin[0] = 1'b1; st = cyc; tick(2);
        bt.din[3:0] = 4'd1;
        bt.tin[0] = 1'b0; tick(16);
        r = nxt(0, st); f = nxt(0, r);
        chk("reorder rise", r - st - 1, 10);
        chk("reorder fall", f - st - 1, 11);

        bt.din[3:0] = 4'd15;
        bt.tin[0] = 1'b1; st = cyc; tick();
        bt.tin[0] = 1'b0; tick();
        chk("ovf before third edge", int'(bt.ovf[0]), 0);
        bt.tin[0] = 1'b1; tick();
        chk("ovf on third edge", int'(bt.ovf[0]), 1);
        tick(35);
        r = nxt(0, st); f = nxt(0, r);
        chk("ovf first pop", r - st - 1, 15);
        chk("ovf second pop", f - st - 1, 16);
        chk("ovf stalled edge", nxt(0, f) - st - 1, 30);
        chk("ovf sticky", int'(bt.ovf[0]), 1);
        bt.clr_ovf = 1'b1; tick();
        bt.clr_ovf = 1'b0;
        chk("ovf cleared", int'(bt.ovf[0]), 0);
        bt.tin[0] = 1'b0; tick(20);

        bi.din[3:0] = 4'd6;
        bi.tin[0] = 1'b1; st = cyc; tick(4);
        bi.tin[0] = 1'b0; tick(14);
        chk("inertial short swallowed", nxt(2, st), -1);
        chk("inertial short idle", int'(bi.busy[0]), 0);
        bi.tin[0] = 1'b1; st = cyc; tick(7);
        bi.tin[0] = 1'b0; tick(16);
        r = nxt(2, st); f = nxt(2, r);
        chk("inertial long delay", r - st - 1, 6);
        chk("inertial long width", f - r, 7);
        bi.tin[0] = 1'b1; st = cyc; tick(6);
        bi.tin[0] = 1'b0; tick(16);
        r = nxt(2, st); f = nxt(2, r);
        chk("inertial collision delay", r - st - 1, 6);
        chk("inertial collision width", f - r, 6);

        bt.din = {4'd3, 4'd12};
        bt.tin = 2'b11; st = cyc; tick(5);
        chk("ch1 independent delay", nxt(1, st) - st - 1, 3);
        chk("ch0 pending tout", int'(bt.tout[0]), 0);
        chk("ch0 pending busy", int'(bt.busy[0]), 1);
        rst = 1'b1; bt.tin = 2'b00; tick(2);
        rst = 1'b0; tick(20);
        chk("reset discards pending", nxt(0, st), -1);
        chk("reset busy cleared", int'(bt.busy[0]), 0);
        rst = 1'b1; bt.din[3:0] = 4'd2; bt.tin[0] = 1'b1; tick();
        rst = 1'b0; st = cyc; tick(6);
        chk("post-reset edge", nxt(0, st) - st - 1, 2);
        bt.tin[0] = 1'b0; tick(5);

        thr = 3;
        for (int n = 0; n < 900; n++) begin
            if (n % 100 == 0) thr = $urandom_range(1, 10);
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, thr) == 0) bt.tin[c] = ~bt.tin[c];
                if ($urandom_range(0, thr) == 0) bi.tin[c] = ~bi.tin[c];
            end
            bt.din = 8'($urandom);
            bi.din = 8'($urandom);
            bt.clr_ovf = $urandom_range(0, 15) == 0;
            bi.clr_ovf = $urandom_range(0, 15) == 0;
            rst = $urandom_range(0, 299) == 0;
            tick();
        end
        rst = 1'b0;
        bt.clr_ovf = 1'b0;
        bi.clr_ovf = 1'b0;
        tick(40);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
